// File: rtl/alu4_cmd_pipe.sv
// Generic synchronous FIFO with a wrap bit on each pointer to tell full from empty.
// Latency: a pushed word is visible at the head one edge after the push.
// Backpressure: push is ignored while full and pop is ignored while empty; full is purely registered state.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; the top bit records which lap each pointer is on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// Command queue in front of alu_4bit with a registered result stage and sticky status.
// Latency: command pushed at edge k into an idle pipe shows out_valid after edge k+1.
// Backpressure: in_ready = !full (registered); result register holds while out_ready is low.
module alu4_cmd_pipe #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_y,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_z,
    input  logic             alu_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_y,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_s,
    output logic             out_err,
    input  logic             clr_sticky,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic [CNT_W-1:0] done_cnt
);
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    cmd_t in_cmd;
    cmd_t head_cmd;
    logic full;
    logic empty;
    logic cap;
    logic illegal;

    assign in_cmd   = '{a: in_a, b: in_b, op: in_op};
    assign in_ready = !full;
    assign cap      = !empty && (!out_valid || out_ready);

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .wr_dat   (in_cmd),
        .pop      (cap),
        .head_dat (head_cmd),
        .full     (full),
        .empty    (empty)
    );

    // Present the queue head to the ALU, forced to zero when nothing is queued.
    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_op = 3'd0;
        if (!empty) begin
            alu_a  = head_cmd.a;
            alu_b  = head_cmd.b;
            alu_op = head_cmd.op;
        end
    end

    // Opcodes above XOR have no ALU meaning; their results are replaced by zeros and an error bit.
    assign illegal = (head_cmd.op > 3'd4);

    // Result holding register: load on capture, drop valid once consumed with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= 4'd0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            out_z     <= 1'b0;
            out_s     <= 1'b0;
            out_err   <= 1'b0;
        end else if (cap) begin
            out_valid <= 1'b1;
            out_err   <= illegal;
            out_y     <= illegal ? 4'd0 : alu_y;
            out_c     <= illegal ? 1'b0 : alu_c;
            out_v     <= illegal ? 1'b0 : alu_v;
            out_z     <= illegal ? 1'b0 : alu_z;
            out_s     <= illegal ? 1'b0 : alu_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status path: clear wins over a same-edge capture; illegal commands count but never set sticky bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
            done_cnt <= '0;
        end else if (clr_sticky) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
            done_cnt <= '0;
        end else if (cap) begin
            done_cnt <= done_cnt + CNT_ONE;
            if (!illegal) begin
                sticky_c <= sticky_c | alu_c;
                sticky_v <= sticky_v | alu_v;
            end
        end
    end
endmodule

// File: tb/tb_alu4_cmd_pipe.sv
module tb_alu4_cmd_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_y;
    logic       alu_c;
    logic       alu_v;
    logic       alu_z;
    logic       alu_s;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic       out_c;
    logic       out_v;
    logic       out_z;
    logic       out_s;
    logic       out_err;
    logic       clr_sticky;
    logic       sticky_c;
    logic       sticky_v;
    logic [7:0] done_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu4_cmd_pipe #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .alu_z      (alu_z),
        .alu_s      (alu_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_z      (out_z),
        .out_s      (out_s),
        .out_err    (out_err),
        .clr_sticky (clr_sticky),
        .sticky_c   (sticky_c),
        .sticky_v   (sticky_v),
        .done_cnt   (done_cnt)
    );

    // Reference 4-bit ALU; illegal opcodes deliberately return nonzero junk with c=v=1.
    always_comb begin
        logic [4:0] sum;
        sum   = 5'd0;
        alu_y = 4'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            3'd0: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = sum[3:0];
                alu_c = sum[4];
                alu_v = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
            end
            3'd1: begin
                sum   = {1'b0, alu_a} - {1'b0, alu_b};
                alu_y = sum[3:0];
                alu_c = !sum[4];
                alu_v = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
            end
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            default: begin
                alu_y = 4'hF;
                alu_c = 1'b1;
                alu_v = 1'b1;
            end
        endcase
        alu_z = (alu_y == 4'd0);
        alu_s = alu_y[3];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = 4'd0;
        in_b       = 4'd0;
        in_op      = 3'd0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_y", 32'(out_y), 0);
        chk("rst_flags", 32'({out_c, out_v, out_z, out_s}), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_sticky", 32'({sticky_c, sticky_v}), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        chk("rst_alu_bus", 32'({alu_a, alu_b, alu_op}), 0);
        rst = 1'b0;
        tick();

        // Single ADD 7+1: no bypass, result after the second edge.
        out_ready = 1'b1;
        drive(4'd7, 4'd1, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("add_no_bypass", 32'(out_valid), 0);
        chk("add_head_a", 32'(alu_a), 7);
        tick();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_y", 32'(out_y), 4'b1000);
        chk("add_flags_cvzs", 32'({out_c, out_v, out_z, out_s}), 4'b0101);
        chk("add_err", 32'(out_err), 0);
        chk("add_sticky_cv", 32'({sticky_c, sticky_v}), 2'b01);
        chk("add_done_cnt", 32'(done_cnt), 1);
        tick();
        chk("add_valid_drop", 32'(out_valid), 0);
        chk("add_y_hold", 32'(out_y), 4'b1000);

        // Back-to-back ADD 15+1, SUB 5-3, SUB 3-5.
        drive(4'd15, 4'd1, 3'd0);
        tick();
        drive(4'd5, 4'd3, 3'd1);
        tick();
        chk("b2b1_valid", 32'(out_valid), 1);
        chk("b2b1_y", 32'(out_y), 4'b0000);
        chk("b2b1_flags", 32'({out_c, out_v, out_z, out_s}), 4'b1010);
        drive(4'd3, 4'd5, 3'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b2_valid", 32'(out_valid), 1);
        chk("b2b2_y", 32'(out_y), 4'b0010);
        chk("b2b2_flags", 32'({out_c, out_v, out_z, out_s}), 4'b1000);
        tick();
        chk("b2b3_valid", 32'(out_valid), 1);
        chk("b2b3_y", 32'(out_y), 4'b1110);
        chk("b2b3_flags", 32'({out_c, out_v, out_z, out_s}), 4'b0001);
        tick();
        chk("b2b_drain", 32'(out_valid), 0);
        chk("b2b_done_cnt", 32'(done_cnt), 4);
        chk("b2b_sticky_cv", 32'({sticky_c, sticky_v}), 2'b11);

        // Backpressure: DEPTH queued plus one held, then a refused push at full.
        out_ready = 1'b0;
        drive(4'd12, 4'd10, 3'd2);
        chk("bp_ready0", 32'(in_ready), 1);
        tick();
        drive(4'd12, 4'd10, 3'd3);
        tick();
        chk("bp_held_valid", 32'(out_valid), 1);
        chk("bp_held_y", 32'(out_y), 4'b1000);
        drive(4'd12, 4'd10, 3'd4);
        tick();
        drive(4'd0, 4'd5, 3'd2);
        tick();
        drive(4'd3, 4'd4, 3'd3);
        chk("bp_ready4", 32'(in_ready), 1);
        tick();
        chk("bp_full", 32'(in_ready), 0);
        drive(4'd9, 4'd3, 3'd4);
        tick();
        tick();
        chk("bp_still_full", 32'(in_ready), 0);
        chk("bp_y_stable", 32'(out_y), 4'b1000);
        chk("bp_cnt", 32'(done_cnt), 5);
        out_ready = 1'b1;
        tick();
        chk("full_pop_y", 32'(out_y), 4'b1110);
        chk("full_refused_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("drain_xor_y", 32'(out_y), 4'b0110);
        tick();
        chk("drain_and0_y", 32'(out_y), 4'b0000);
        chk("drain_and0_flags", 32'({out_c, out_v, out_z, out_s}), 4'b0010);
        tick();
        chk("drain_or_y", 32'(out_y), 4'b0111);
        tick();
        chk("drain_late_y", 32'(out_y), 4'b1010);
        chk("drain_late_valid", 32'(out_valid), 1);
        tick();
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_cnt", 32'(done_cnt), 10);

        // Illegal opcode after clearing the status path.
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_sticky", 32'({sticky_c, sticky_v}), 0);
        chk("clr_cnt", 32'(done_cnt), 0);
        drive(4'd9, 4'd9, 3'd6);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ill_err", 32'(out_err), 1);
        chk("ill_y", 32'(out_y), 0);
        chk("ill_flags", 32'({out_c, out_v, out_z, out_s}), 0);
        chk("ill_sticky", 32'({sticky_c, sticky_v}), 0);
        chk("ill_cnt", 32'(done_cnt), 1);
        drive(4'd1, 4'd1, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("legal_err", 32'(out_err), 0);
        chk("legal_y", 32'(out_y), 2);
        chk("legal_cnt", 32'(done_cnt), 2);

        // Clear coinciding with a capture that would set sticky_v.
        drive(4'd7, 4'd1, 3'd0);
        tick();
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clrcap_y", 32'(out_y), 4'b1000);
        chk("clrcap_cnt", 32'(done_cnt), 0);
        chk("clrcap_sticky", 32'({sticky_c, sticky_v}), 0);
        tick();

        // Asynchronous reset with one held result and three queued commands.
        out_ready = 1'b0;
        drive(4'd1, 4'd2, 3'd0);
        tick();
        drive(4'd2, 4'd2, 3'd0);
        tick();
        drive(4'd3, 4'd3, 3'd0);
        tick();
        drive(4'd4, 4'd4, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_y", 32'(out_y), 3);
        chk("pre_rst_cnt", 32'(done_cnt), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_y", 32'(out_y), 0);
        chk("arst_ready", 32'(in_ready), 1);
        chk("arst_alu_a", 32'(alu_a), 0);
        chk("arst_cnt", 32'(done_cnt), 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(4'd5, 4'd6, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_y", 32'(out_y), 4'b1011);
        chk("post_rst_flags", 32'({out_c, out_v, out_z, out_s}), 4'b0101);
        chk("post_rst_cnt", 32'(done_cnt), 1);
        tick();
        chk("post_rst_only_own", 32'(out_valid), 0);
        chk("post_rst_cnt_final", 32'(done_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
